// File: rtl/pcie_cdc_afifo_pkg.sv
// Shared definitions for the PCIe CDC async FIFO write side: word layout,
// widths and the write-arbiter state encoding.
package pcie_cdc_afifo_pkg;

    localparam int PCIE_AFIFO_DW = 73;
    localparam int PCIE_BEAT_DW  = 64;
    localparam int PCIE_STRB_W   = 8;

    // FIFO word: last flag on top, then byte strobes, then the data beat.
    typedef struct packed {
        logic                    last;
        logic [PCIE_STRB_W-1:0]  strb;
        logic [PCIE_BEAT_DW-1:0] data;
    } pcie_afifo_word_t;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_IDLE     = 2'd1,
        ST_BURST    = 2'd2
    } pcie_wr_arb_state_t;

    function automatic pcie_afifo_word_t pack_word(
        input logic                    last,
        input logic [PCIE_STRB_W-1:0]  strb,
        input logic [PCIE_BEAT_DW-1:0] data
    );
        pcie_afifo_word_t w;
        w.last = last;
        w.strb = strb;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/pcie_cdc_afifo_wr_arb_if.sv
// Requester and FIFO write-port bundle for the write arbiter.
// master: requesters plus FIFO status; slave: the arbiter.
interface pcie_cdc_afifo_wr_arb_if
    import pcie_cdc_afifo_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]              i_req_valid;
    logic [NREQ*PCIE_BEAT_DW-1:0] i_req_data;
    logic [NREQ*PCIE_STRB_W-1:0]  i_req_strb;
    logic [NREQ-1:0]              i_req_last;
    logic [NREQ-1:0]              o_req_ready;
    logic [NREQ-1:0]              o_grant;
    logic [PCIE_AFIFO_DW-1:0]     o_fifo_din;
    logic                         o_fifo_wr_en;
    logic                         i_fifo_full;

    modport master (
        output i_req_valid, i_req_data, i_req_strb, i_req_last, i_fifo_full,
        input  o_req_ready, o_grant, o_fifo_din, o_fifo_wr_en
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_strb, i_req_last, i_fifo_full,
        output o_req_ready, o_grant, o_fifo_din, o_fifo_wr_en
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// i_ptr (wrapping) wins. Rotate requests down by the pointer, isolate the
// lowest set bit, rotate the one-hot result back up.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant
);
    logic [NREQ-1:0] w_rot_req;
    logic [NREQ-1:0] w_rot_gnt;

    assign w_rot_req = NREQ'({i_req, i_req} >> i_ptr);
    assign w_rot_gnt = w_rot_req & (~w_rot_req + 1'b1);
    assign o_grant   = NREQ'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> NREQ);

endmodule

// File: rtl/pcie_cdc_afifo_wr_arb.sv
// Write-side scheduler for the PCIe CDC async FIFO. Hands the single FIFO
// write port to one requester for a whole packet, round-robin between
// packets, and holds off all writes while the FIFO is in its post-reset
// busy window.
module pcie_cdc_afifo_wr_arb
    import pcie_cdc_afifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int RST_WAIT  = 16,
    parameter int MAX_BEATS = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    pcie_cdc_afifo_wr_arb_if.slave  io_bus,
    output logic                    o_busy,
    output logic                    o_err_overlen
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    pcie_wr_arb_state_t r_state, r_state_next;
    logic [WW-1:0]      r_wait_cnt, r_wait_cnt_next;
    logic [PW-1:0]      r_rr_ptr, r_rr_ptr_next;
    logic [PW-1:0]      r_owner, r_owner_next;
    logic [NREQ-1:0]    r_grant, r_grant_next;
    logic [BW-1:0]      r_beat_cnt, r_beat_cnt_next;
    logic               r_err_overlen, r_err_overlen_next;

    logic [NREQ-1:0]          w_arb_grant;
    logic [PW-1:0]            w_arb_idx;
    logic [PCIE_AFIFO_DW-1:0] w_slice [NREQ];
    logic [PCIE_AFIFO_DW-1:0] w_sel_word;
    logic                     w_sel_valid;
    logic                     w_sel_last;
    logic                     w_in_burst;
    logic                     w_wr_en;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .i_req   (io_bus.i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant)
    );

    // Pack each requester's current beat into FIFO word layout.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_slice[gi] = pack_word(io_bus.i_req_last[gi],
                                           io_bus.i_req_strb[gi*PCIE_STRB_W +: PCIE_STRB_W],
                                           io_bus.i_req_data[gi*PCIE_BEAT_DW +: PCIE_BEAT_DW]);
        end
    endgenerate

    // Encode the one-hot arbiter result so the owner index can drive the pointer update.
    always_comb begin
        w_arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_arb_grant[k]) begin
                w_arb_idx = PW'(k);
            end
        end
    end

    // AND-OR select of the granted requester's word and valid; zero when nobody owns the port.
    always_comb begin
        w_sel_word  = '0;
        w_sel_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_sel_word  = w_sel_word | w_slice[k];
                w_sel_valid = w_sel_valid | io_bus.i_req_valid[k];
            end
        end
    end

    assign w_sel_last = w_sel_word[PCIE_AFIFO_DW-1];
    assign w_in_burst = (r_state == ST_BURST);
    assign w_wr_en    = w_in_burst & w_sel_valid & ~io_bus.i_fifo_full;

    assign io_bus.o_fifo_wr_en = w_wr_en;
    assign io_bus.o_req_ready  = r_grant & {NREQ{w_wr_en}};
    assign io_bus.o_grant      = r_grant;
    assign io_bus.o_fifo_din   = w_in_burst ? w_sel_word : '0;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_err_overlen       = r_err_overlen;

    // Next-state: reset hold countdown, idle arbitration, packet-atomic burst.
    always_comb begin
        r_state_next       = r_state;
        r_wait_cnt_next    = r_wait_cnt;
        r_rr_ptr_next      = r_rr_ptr;
        r_owner_next       = r_owner;
        r_grant_next       = r_grant;
        r_beat_cnt_next    = r_beat_cnt;
        r_err_overlen_next = r_err_overlen;
        unique case (r_state)
            ST_RST_HOLD: begin
                if (r_wait_cnt == WW'(RST_WAIT - 1)) begin
                    r_state_next = ST_IDLE;
                end else begin
                    r_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (|io_bus.i_req_valid) begin
                    r_grant_next = w_arb_grant;
                    r_owner_next = w_arb_idx;
                    r_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_wr_en) begin
                    // Counter saturates; any beat beyond the limit flags the error but is still written.
                    if (r_beat_cnt == BW'(MAX_BEATS)) begin
                        r_err_overlen_next = 1'b1;
                    end else begin
                        r_beat_cnt_next = r_beat_cnt + 1'b1;
                    end
                    if (w_sel_last) begin
                        r_state_next    = ST_IDLE;
                        r_grant_next    = '0;
                        r_beat_cnt_next = '0;
                        r_rr_ptr_next   = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                    end
                end
            end
            default: begin
                r_state_next = ST_RST_HOLD;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-packet abandons it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RST_HOLD;
            r_wait_cnt    <= '0;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_grant       <= '0;
            r_beat_cnt    <= '0;
            r_err_overlen <= 1'b0;
        end else begin
            r_state       <= r_state_next;
            r_wait_cnt    <= r_wait_cnt_next;
            r_rr_ptr      <= r_rr_ptr_next;
            r_owner       <= r_owner_next;
            r_grant       <= r_grant_next;
            r_beat_cnt    <= r_beat_cnt_next;
            r_err_overlen <= r_err_overlen_next;
        end
    end

endmodule

// File: tb/tb_pcie_cdc_afifo_wr_arb.sv
// Bench for the FIFO write arbiter: queue-based requesters, a packet-level
// round-robin reference model and a write scoreboard.
module tb_pcie_cdc_afifo_wr_arb;
    import pcie_cdc_afifo_pkg::*;

    localparam int NREQ = 4;
    localparam int MAXB = 256;
    localparam logic [72:0] DEAD_WORD = 73'h1_FF_DEADBEEF01234567;

    typedef logic [72:0] word_t;
    typedef struct packed {
        logic [1:0] req;
        word_t      w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    pcie_cdc_afifo_wr_arb_if #(.NREQ(NREQ)) bus_if ();

    pcie_cdc_afifo_wr_arb #(
        .NREQ      (NREQ),
        .RST_WAIT  (16),
        .MAX_BEATS (MAXB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .io_bus        (bus_if),
        .o_busy        (busy),
        .o_err_overlen (err)
    );

    word_t rq [NREQ][$];
    word_t mq [NREQ][$];
    exp_t  exp_q [$];
    int    wcyc [$];
    bit    pkt_start [NREQ];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_total = 0;
    int cnt_dead = 0;
    int m_ptr = 0;
    bit m_err = 1'b0;
    int full_mode = 0;
    int full_pct = 0;
    int drop_pct = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic redrive();
        logic  v;
        word_t hd;
        for (int n = 0; n < NREQ; n++) begin
            v  = (rq[n].size() != 0);
            hd = '0;
            if (v) hd = rq[n][0];
            if (v && !pkt_start[n] && ($urandom_range(99) < drop_pct)) v = 1'b0;
            bus_if.i_req_valid[n]         = v;
            bus_if.i_req_last[n]          = hd[72];
            bus_if.i_req_strb[n*8 +: 8]   = hd[71:64];
            bus_if.i_req_data[n*64 +: 64] = hd[63:0];
        end
        case (full_mode)
            1:       bus_if.i_fifo_full = 1'b1;
            2:       bus_if.i_fifo_full = ($urandom_range(99) < full_pct);
            default: bus_if.i_fifo_full = 1'b0;
        endcase
    endtask

    task automatic tick();
        logic [NREQ-1:0] acc;
        exp_t  e;
        word_t w;
        @(negedge clk);
        acc = '0;
        if (chk_en) begin
            acc = bus_if.o_req_ready;
            if (bus_if.o_fifo_wr_en === 1'b1) begin
                wr_total++;
                wcyc.push_back(cyc);
                if (bus_if.o_fifo_din === DEAD_WORD) cnt_dead++;
                if (bus_if.i_fifo_full === 1'b1) chk("wr_while_full", 73'(bus_if.o_fifo_wr_en), 73'd0);
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_write obs=%0h exp=none", bus_if.o_fifo_din);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("din", bus_if.o_fifo_din, e.w);
                    chk("ready", 73'(bus_if.o_req_ready), 73'(4'b0001 << e.req));
                end
            end else begin
                chk("ready_nowrite", 73'(bus_if.o_req_ready), 73'd0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int n = 0; n < NREQ; n++) begin
            if (acc[n] === 1'b1 && rq[n].size() != 0) begin
                w = rq[n].pop_front();
                pkt_start[n] = w[72];
            end
        end
        redrive();
        #1;
    endtask

    task automatic add_word(input int n, input word_t w);
        rq[n].push_back(w);
        mq[n].push_back(w);
    endtask

    task automatic add_pkt(input int n, input int len);
        word_t w;
        for (int b = 0; b < len; b++) begin
            w = {(b == len - 1), 8'($urandom), 32'($urandom), 32'($urandom)};
            add_word(n, w);
        end
    endtask

    // Packet-level round robin over every requester that has a packet pending.
    task automatic run_model();
        int    g;
        int    len;
        int    c;
        word_t w;
        while (1) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (g < 0 && mq[c].size() != 0) g = c;
            end
            if (g < 0) break;
            len = 0;
            do begin
                w = mq[g].pop_front();
                exp_q.push_back({2'(g), w});
                len++;
            end while (!w[72]);
            if (len > MAXB) m_err = 1'b1;
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout obs=%0d exp=0 words pending", tag, exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (wr_total < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 73'(wr_total), 73'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        full_mode = 0;
        drop_pct = 0;
        for (int n = 0; n < NREQ; n++) begin
            rq[n].delete();
            mq[n].delete();
            pkt_start[n] = 1'b1;
        end
        exp_q.delete();
        m_ptr = 0;
        m_err = 1'b0;
        redrive();
        repeat (2) tick();
        chk_en = 1'b1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t first_w;
        int    base;

        // Test 1: reset values, hold window, first grant and write.
        bus_if.i_req_valid = '0;
        bus_if.i_req_data  = '0;
        bus_if.i_req_strb  = '0;
        bus_if.i_req_last  = '0;
        bus_if.i_fifo_full = 1'b0;
        do_reset();
        add_pkt(0, 2);
        run_model();
        first_w = exp_q[0].w;
        redrive();
        #1;
        chk("rst_grant", 73'(bus_if.o_grant), 73'd0);
        chk("rst_busy", 73'(busy), 73'd1);
        chk("rst_wr_en", 73'(bus_if.o_fifo_wr_en), 73'd0);
        chk("rst_ready", 73'(bus_if.o_req_ready), 73'd0);
        chk("rst_err", 73'(err), 73'd0);
        chk("rst_din", bus_if.o_fifo_din, 73'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("hold_wr_en", 73'(bus_if.o_fifo_wr_en), 73'd0);
            chk("hold_grant", 73'(bus_if.o_grant), 73'd0);
            chk("hold_busy", 73'(busy), (k == 16) ? 73'd0 : 73'd1);
        end
        tick();
        chk("t1_grant", 73'(bus_if.o_grant), 73'd1);
        chk("t1_wr_en", 73'(bus_if.o_fifo_wr_en), 73'd1);
        chk("t1_din", bus_if.o_fifo_din, first_w);
        drain(50, "t1");

        // Test 2: four requesters with 2-beat packets, req0 twice.
        do_reset();
        for (int n = 0; n < NREQ; n++) add_pkt(n, 2);
        add_pkt(0, 2);
        run_model();
        redrive();
        #1;
        wcyc.delete();
        drain(100, "t2");
        chk("t2_writes", 73'(wcyc.size()), 73'd10);
        if (wcyc.size() == 10) begin
            chk("t2_span", 73'(wcyc[9] - wcyc[0]), 73'd13);
            chk("t2_beat_gap", 73'(wcyc[1] - wcyc[0]), 73'd1);
            chk("t2_pkt_gap", 73'(wcyc[2] - wcyc[1]), 73'd2);
        end

        // Test 3: full stall mid-packet holds the grant.
        add_pkt(1, 4);
        run_model();
        redrive();
        #1;
        base = wr_total;
        wait_writes(base + 1, 20, "t3_first_beat");
        full_mode = 1;
        redrive();
        #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_stall_wr_en", 73'(bus_if.o_fifo_wr_en), 73'd0);
            chk("t3_stall_grant", 73'(bus_if.o_grant), 73'b0010);
        end
        chk("t3_stall_count", 73'(wr_total), 73'(base + 1));
        full_mode = 0;
        drain(50, "t3");

        // Test 4: 257-beat packet raises the sticky overlength error.
        add_pkt(2, 257);
        run_model();
        redrive();
        #1;
        base = wr_total;
        wait_writes(base + 256, 400, "t4_256_beats");
        chk("t4_err_at_256", 73'(err), 73'd0);
        wait_writes(base + 257, 10, "t4_257_beats");
        chk("t4_err_at_257", 73'(err), 73'd1);
        drain(20, "t4");
        repeat (5) tick();
        chk("t4_err_sticky", 73'(err), 73'(m_err));
        chk("t4_idle", 73'(busy), 73'd0);

        // Test 5: reset during beat 3 of a 6-beat packet.
        do_reset();
        chk("t5_err_cleared", 73'(err), 73'd0);
        add_pkt(1, 6);
        run_model();
        redrive();
        #1;
        base = wr_total;
        wait_writes(base + 2, 60, "t5_two_beats");
        rst = 1'b1;
        tick();
        chk("t5_wr_en", 73'(bus_if.o_fifo_wr_en), 73'd0);
        chk("t5_grant", 73'(bus_if.o_grant), 73'd0);
        chk("t5_busy", 73'(busy), 73'd1);
        do_reset();

        // Test 6: single-beat packet from req3; req0 also pending checks pointer returned to 0.
        cnt_dead = 0;
        add_pkt(0, 3);
        add_word(3, DEAD_WORD);
        run_model();
        redrive();
        #1;
        drain(80, "t6");
        chk("t6_written_once", 73'(cnt_dead), 73'd1);

        // Test 7: randomized packets with random full and mid-packet valid gaps.
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < NREQ; n++) begin
                int np;
                np = int'($urandom_range(3, 1));
                for (int p = 0; p < np; p++) add_pkt(n, int'($urandom_range(8, 1)));
            end
            run_model();
            full_mode = 2;
            full_pct = 30;
            drop_pct = 25;
            redrive();
            #1;
            drain(3000, "t7");
            full_mode = 0;
            drop_pct = 0;
            redrive();
            #1;
            chk("t7_err", 73'(err), 73'(m_err));
            chk("t7_idle", 73'(busy), 73'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
